// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the floating-point operation sequencer.
package fp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } fsm_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_pair_t;

endpackage

// File: rtl/fp_seq_fifo.sv
// Operand-pair FIFO: registered pointers/count, head word read combinationally.
module fp_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Front end for a start/ready FP unit: buffers operand pairs, issues them one at a
// time, returns results on a valid/ready stream and replaces hung ops with a qNaN.
module fp_op_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_start,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic        out_timeout,
  output logic        busy,
  output logic [1:0]  dbg_state
);
  // Both streams transfer on a rising edge where valid && ready; a producer never
  // withdraws valid or changes data until that transfer happens.
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fsm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fpu_a_q, fpu_a_d;
  logic [31:0]   fpu_b_q, fpu_b_d;
  logic [31:0]   out_c_q, out_c_d;
  logic          fpu_start_q, fpu_start_d;
  logic          out_valid_q, out_valid_d;
  logic          out_timeout_q, out_timeout_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  op_pair_t      push_pair, head_pair;
  logic [63:0]   head_raw;

  assign push_pair = '{a: in_a, b: in_b};
  assign head_pair = op_pair_t'(head_raw);
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  fp_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_pair),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    out_c_d       = out_c_q;
    out_valid_d   = out_valid_q;
    out_timeout_d = out_timeout_q;
    fpu_start_d   = 1'b0;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          fpu_a_d     = head_pair.a;
          fpu_b_d     = head_pair.b;
          fpu_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      // Ready at cnt 0 may be left over from the previous op, so it is not trusted.
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (fpu_ready && (cnt_q != '0)) begin
          out_c_d       = fpu_c;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          out_c_d       = FP_QNAN;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            fpu_a_d     = head_pair.a;
            fpu_b_d     = head_pair.b;
            fpu_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      out_c_q       <= '0;
      fpu_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      out_c_q       <= out_c_d;
      fpu_start_q   <= fpu_start_d;
      out_valid_q   <= out_valid_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign fpu_start   = fpu_start_q;
  assign out_c       = out_c_q;
  assign out_valid   = out_valid_q;
  assign out_timeout = out_timeout_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Bench for fp_op_sequencer: behavioural FP unit model plus an expected-result queue.
`timescale 1ns/1ps
module tb_fp_op_sequencer;
  import fp_seq_pkg::*;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 32;
  localparam int MDL_DELAY = 26;
  localparam int LAT       = MDL_DELAY + 3;
  localparam logic [31:0] STALE_C = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_start;
  logic        fpu_ready = 1'b0;
  logic [31:0] fpu_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_c;
  logic        out_timeout;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int push_cyc = 0;
  int start_cnt = 0;
  int start_run = 0;
  int start_run_max = 0;

  logic        m_stale = 1'b0;
  logic        m_hang = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  fp_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_start   (fpu_start),
    .fpu_ready   (fpu_ready),
    .fpu_c       (fpu_c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c       (out_c),
    .out_timeout (out_timeout),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Unit result function: the one known product, otherwise an arbitrary asymmetric mix.
  function automatic logic [31:0] unit_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0101_0101;
  endfunction

  // Unit model: sees start at an edge, raises ready MDL_DELAY edges later.
  always @(posedge clk) begin
    if (fpu_start) begin
      m_a       <= fpu_a;
      m_b       <= fpu_b;
      m_cnt     <= 1;
      m_busy    <= 1'b1;
      fpu_ready <= m_stale;
      if (m_stale) fpu_c <= STALE_C;
    end else if (m_busy) begin
      if (!m_hang && m_cnt == MDL_DELAY) begin
        fpu_ready <= 1'b1;
        fpu_c     <= unit_f(m_a, m_b);
        m_busy    <= 1'b0;
      end else begin
        fpu_ready <= 1'b0;
        m_cnt     <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fpu_start) begin
      start_cnt <= start_cnt + 1;
      start_run <= start_run + 1;
      if (start_run + 1 > start_run_max) start_run_max <= start_run + 1;
    end else begin
      start_run <= 0;
    end
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic exp_to);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_wait in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    exp_q.push_back(exp_to ? {1'b1, FP_QNAN} : {1'b0, unit_f(a, b)});
    @(negedge clk);
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fpu_start, out_valid, out_timeout} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl start/valid/timeout=%b required=000", {fpu_start, out_valid, out_timeout});
    end
    checks++;
    if (fpu_a !== '0 || fpu_b !== '0 || out_c !== '0) begin
      failures++; $display("FAIL reset_data a=%h b=%h c=%h required=0", fpu_a, fpu_b, out_c);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_flags busy=%b in_ready=%b required busy=0 in_ready=1", busy, in_ready);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_state state=%0d required=%0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n, s0, lat;
    logic [32:0] exp;
    out_ready = 1'b1;
    s0 = start_cnt;
    push_pair(32'h3FC0_0000, 32'h4000_0000, 1'b0);
    @(negedge clk);
    checks++;
    if (fpu_start !== 1'b1 || fpu_a !== 32'h3FC0_0000 || fpu_b !== 32'h4000_0000) begin
      failures++; $display("FAIL single_issue start=%b a=%h b=%h required start=1 a=3fc00000 b=40000000", fpu_start, fpu_a, fpu_b);
    end
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    lat = cyc - push_cyc;
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL single_latency got=%0d required=%0d", lat, LAT); end
    checks++;
    if (out_c !== 32'h4040_0000 || out_timeout !== 1'b0) begin
      failures++; $display("FAIL single_result c=%h to=%b required c=40400000 to=0", out_c, out_timeout);
    end
    exp = exp_q.pop_front();
    checks++;
    if (start_cnt - s0 != 1 || start_run_max != 1) begin
      failures++; $display("FAIL single_start pulses=%0d run=%0d required 1 and 1", start_cnt - s0, start_run_max);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, gaps, last;
    logic [32:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready4 got=%b required=1", in_ready); end
      end
      push_pair($urandom, $urandom, 1'b0);
    end
    gaps = 0; last = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 80) begin
        @(negedge clk); n++;
        if (dbg_state === ST_IDLE && !out_valid) gaps++;
      end
      checks++;
      if (!out_valid) begin failures++; $display("FAIL b2b_wait%0d out_valid=0 required=1", i); end
      if (i > 0) begin
        checks++;
        if (cyc - last != LAT) begin failures++; $display("FAIL b2b_interval%0d got=%0d required=%0d", i, cyc - last, LAT); end
      end
      last = cyc;
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL b2b_sb_empty got=%h required=none", {out_timeout, out_c});
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_timeout, out_c} !== exp) begin failures++; $display("FAIL b2b_result%0d got=%h required=%h", i, {out_timeout, out_c}, exp); end
      end
      @(negedge clk);
    end
    checks++;
    if (gaps != 0) begin failures++; $display("FAIL b2b_idle_gap got=%0d required=0", gaps); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy=%b required=0", busy); end
  endtask

  task automatic test_backpressure();
    int n, s0, err_stable, err_ready;
    logic [31:0] held;
    logic [32:0] exp;
    out_ready = 1'b0;
    push_pair($urandom, $urandom, 1'b0);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_first out_valid=0 required=1"); end
    held = out_c;
    s0 = start_cnt;
    for (int i = 0; i < DEPTH; i++) push_pair($urandom, $urandom, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full in_ready=%b required=0", in_ready); end
    err_stable = 0; err_ready = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_c !== held) err_stable++;
      if (in_ready !== 1'b0) err_ready++;
    end
    checks++;
    if (err_stable != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d required=0", err_stable); end
    checks++;
    if (err_ready != 0) begin failures++; $display("FAIL bp_in_ready open_cycles=%0d required=0", err_ready); end
    checks++;
    if (start_cnt != s0) begin failures++; $display("FAIL bp_no_start pulses=%0d required=0", start_cnt - s0); end
    out_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      n = 0;
      while (!out_valid && n < 80) begin @(negedge clk); n++; end
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL bp_sb_empty got=%h required=none", {out_timeout, out_c});
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_timeout, out_c} !== exp) begin failures++; $display("FAIL bp_result%0d got=%h required=%h", i, {out_timeout, out_c}, exp); end
      end
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_pop_frees in_ready=%b required=1", in_ready); end
      end
    end
  endtask

  task automatic test_watchdog();
    int n, lat;
    logic [32:0] exp;
    out_ready = 1'b1;
    m_hang = 1'b1;
    push_pair(32'h4120_0000, 32'hC0A0_0000, 1'b1);
    n = 0;
    while (!out_valid && n < 80) begin @(negedge clk); n++; end
    lat = cyc - push_cyc;
    checks++;
    if (lat != TIMEOUT + 2) begin failures++; $display("FAIL wd_latency got=%0d required=%0d", lat, TIMEOUT + 2); end
    exp = exp_q.pop_front();
    checks++;
    if ({out_timeout, out_c} !== exp) begin failures++; $display("FAIL wd_result got=%h required=%h", {out_timeout, out_c}, exp); end
    @(negedge clk);
    m_hang = 1'b0;
    push_pair(32'h3F80_0000, 32'h3F00_0000, 1'b0);
    n = 0;
    while (!out_valid && n < 80) begin @(negedge clk); n++; end
    lat = cyc - push_cyc;
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL wd_next_latency got=%0d required=%0d", lat, LAT); end
    exp = exp_q.pop_front();
    checks++;
    if ({out_timeout, out_c} !== exp) begin failures++; $display("FAIL wd_next_result got=%h required=%h", {out_timeout, out_c}, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int c0, s0, seen_valid, seen_busy;
    out_ready = 1'b1;
    push_pair($urandom, $urandom, 1'b0);
    c0 = push_cyc;
    push_pair($urandom, $urandom, 1'b0);
    push_pair($urandom, $urandom, 1'b0);
    while (cyc < c0 + 12) @(negedge clk);
    checks++;
    if (dbg_state !== ST_WAIT || busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre state=%0d busy=%b required state=%0d busy=1", dbg_state, busy, ST_WAIT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fpu_start, out_valid, out_timeout} !== 3'b000 || fpu_a !== '0 || fpu_b !== '0 || out_c !== '0) begin
      failures++; $display("FAIL rst_async_out ctl=%b a=%h b=%h c=%h required all 0", {fpu_start, out_valid, out_timeout}, fpu_a, fpu_b, out_c);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL rst_async_flags busy=%b in_ready=%b state=%0d required 0 1 0", busy, in_ready, dbg_state);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt; seen_valid = 0; seen_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen_valid++;
      if (busy !== 1'b0) seen_busy++;
    end
    checks++;
    if (seen_valid != 0) begin failures++; $display("FAIL rst_no_result valid_cycles=%0d required=0", seen_valid); end
    checks++;
    if (start_cnt != s0 || seen_busy != 0) begin
      failures++; $display("FAIL rst_flushed starts=%0d busy_cycles=%0d required 0 and 0", start_cnt - s0, seen_busy);
    end
  endtask

  task automatic test_stale_ready();
    int n, lat;
    logic [32:0] exp;
    out_ready = 1'b1;
    m_stale = 1'b1;
    push_pair(32'h4049_0FDB, 32'h402D_F854, 1'b0);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    lat = cyc - push_cyc;
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL stale_latency got=%0d required=%0d", lat, LAT); end
    exp = exp_q.pop_front();
    checks++;
    if ({out_timeout, out_c} !== exp) begin failures++; $display("FAIL stale_result got=%h required=%h", {out_timeout, out_c}, exp); end
    @(negedge clk);
    m_stale = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    test_stale_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
